// File: rtl/speed_test_pkg.sv
// Shared state encoding and widths for the speed-test run controller and its helpers.
package speed_test_pkg;

    localparam int unsigned PORT_CONFIG_WIDTH      = 256;
    localparam int unsigned DEFAULT_DURATION_WIDTH = 40;
    localparam int unsigned DEFAULT_COUNT_WIDTH    = 48;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StRun,
        StStopping,
        StDone
    } state_e;

endpackage

// File: rtl/keep_popcount.sv
// Registered population count of an AXIS keep vector; emits zero on cycles where en is low.
module keep_popcount
    import speed_test_pkg::*;
#(
    parameter int unsigned KEEP_WIDTH = 64,
    parameter int unsigned CNT_WIDTH  = $clog2(KEEP_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [KEEP_WIDTH-1:0] keep,
    output logic [CNT_WIDTH-1:0]  count
);

    logic [CNT_WIDTH-1:0] sum;
    logic [CNT_WIDTH-1:0] count_q;

    // Written as a chain; synthesis rebalances it into a tree.
    always_comb begin
        sum = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            sum = sum + CNT_WIDTH'(keep[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= en ? sum : '0;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/speed_test_controller.sv
// Sequences one timed generator run and snoops its AXIS output for frame/byte statistics.
// Define SPEED_TEST_STOP_TIMEOUT_EN to add the STOPPING watchdog and the stop_timeout port.
module speed_test_controller
    import speed_test_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 512,
    parameter int unsigned DURATION_WIDTH = DEFAULT_DURATION_WIDTH,
    parameter int unsigned COUNT_WIDTH    = DEFAULT_COUNT_WIDTH,
    parameter int unsigned STOP_TIMEOUT   = 65536
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_start,
    input  logic                         cmd_abort,
    input  logic [DURATION_WIDTH-1:0]    cfg_duration,
    input  logic [PORT_CONFIG_WIDTH-1:0] cfg_port_config,
    output logic                         busy,
    output logic                         done,
    output logic                         aborted,
`ifdef SPEED_TEST_STOP_TIMEOUT_EN
    output logic                         stop_timeout,
`endif
    output logic [COUNT_WIDTH-1:0]       frames_sent,
    output logic [COUNT_WIDTH-1:0]       bytes_sent,
    input  logic                         gen_ready,
    output logic                         gen_start,
    output logic                         gen_stop,
    output logic [PORT_CONFIG_WIDTH-1:0] gen_port_config,
    input  logic                         snoop_valid,
    input  logic                         snoop_ready,
    input  logic                         snoop_last,
    input  logic [DATA_WIDTH/8-1:0]      snoop_keep
);

    localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned POP_WIDTH  = $clog2(KEEP_WIDTH + 1);

    state_e                       state_q, state_d;
    logic [DURATION_WIDTH-1:0]    cnt_q, cnt_d;
    logic [PORT_CONFIG_WIDTH-1:0] cfg_q, cfg_d;
    logic                         gen_start_q, gen_start_d;
    logic                         gen_stop_q, gen_stop_d;
    logic                         done_q, done_d;
    logic                         aborted_q, aborted_d;
    logic                         accept;
    logic                         beat;
    logic [POP_WIDTH-1:0]         beat_bytes;
    logic [COUNT_WIDTH-1:0]       frames_q, frames_d;
    logic [COUNT_WIDTH-1:0]       bytes_q, bytes_d;
    logic [COUNT_WIDTH:0]         bytes_sum;

`ifdef SPEED_TEST_STOP_TIMEOUT_EN
    localparam int unsigned WD_WIDTH = $clog2(STOP_TIMEOUT + 1);

    logic [WD_WIDTH-1:0] wd_q;
    logic                timeout_q, timeout_d;
    logic                wd_expired;

    assign wd_expired = (wd_q == WD_WIDTH'(STOP_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || state_q != StStopping) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + WD_WIDTH'(1);
        end
    end
`endif

    // Duration is loaded into the counter at accept and held through ARM, so RUN entry sees it.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cfg_d       = cfg_q;
        gen_start_d = 1'b0;
        gen_stop_d  = 1'b0;
        done_d      = 1'b0;
        aborted_d   = aborted_q;
        accept      = 1'b0;
`ifdef SPEED_TEST_STOP_TIMEOUT_EN
        timeout_d   = timeout_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (cmd_start) begin
                    accept    = 1'b1;
                    cfg_d     = cfg_port_config;
                    cnt_d     = cfg_duration;
                    aborted_d = 1'b0;
`ifdef SPEED_TEST_STOP_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                    state_d   = (cfg_duration == '0) ? StDone : StArm;
                end
            end
            StArm: begin
                if (cmd_abort) begin
                    aborted_d = 1'b1;
                    state_d   = StDone;
                end else if (gen_ready) begin
                    gen_start_d = 1'b1;
                    state_d     = StRun;
                end
            end
            StRun: begin
                cnt_d = cnt_q - DURATION_WIDTH'(1);
                if (cnt_q == DURATION_WIDTH'(1) || cmd_abort) begin
                    gen_stop_d = 1'b1;
                    state_d    = StStopping;
                    if (cmd_abort) begin
                        aborted_d = 1'b1;
                    end
                end
            end
            StStopping: begin
                if (gen_ready) begin
                    state_d = StDone;
                end
`ifdef SPEED_TEST_STOP_TIMEOUT_EN
                else if (wd_expired) begin
                    state_d   = StDone;
                    aborted_d = 1'b1;
                    timeout_d = 1'b1;
                end
`endif
            end
            StDone: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Beats in flight after the stop pulse still count, hence STOPPING is included.
    assign beat = snoop_valid && snoop_ready &&
                  (state_q == StArm || state_q == StRun || state_q == StStopping);

    keep_popcount #(
        .KEEP_WIDTH (KEEP_WIDTH),
        .CNT_WIDTH  (POP_WIDTH)
    ) u_keep_popcount (
        .clk   (clk),
        .rst   (rst),
        .en    (beat),
        .keep  (snoop_keep),
        .count (beat_bytes)
    );

    assign bytes_sum = {1'b0, bytes_q} + (COUNT_WIDTH + 1)'(beat_bytes);

    always_comb begin
        frames_d = frames_q;
        bytes_d  = bytes_q;
        if (accept) begin
            frames_d = '0;
            bytes_d  = '0;
        end else begin
            if (beat && snoop_last && frames_q != '1) begin
                frames_d = frames_q + COUNT_WIDTH'(1);
            end
            bytes_d = bytes_sum[COUNT_WIDTH] ? '1 : bytes_sum[COUNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            cfg_q       <= '0;
            gen_start_q <= 1'b0;
            gen_stop_q  <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            frames_q    <= '0;
            bytes_q     <= '0;
`ifdef SPEED_TEST_STOP_TIMEOUT_EN
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cfg_q       <= cfg_d;
            gen_start_q <= gen_start_d;
            gen_stop_q  <= gen_stop_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            frames_q    <= frames_d;
            bytes_q     <= bytes_d;
`ifdef SPEED_TEST_STOP_TIMEOUT_EN
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign busy            = (state_q != StIdle);
    assign done            = done_q;
    assign aborted         = aborted_q;
    assign frames_sent     = frames_q;
    assign bytes_sent      = bytes_q;
    assign gen_start       = gen_start_q;
    assign gen_stop        = gen_stop_q;
    assign gen_port_config = cfg_q;
`ifdef SPEED_TEST_STOP_TIMEOUT_EN
    assign stop_timeout    = timeout_q;
`endif

endmodule

// File: tb/tb_speed_test_controller.sv
// Directed bench for speed_test_controller: run timing, abort, ready stalls, reset, saturation.
module tb_speed_test_controller;

    localparam int unsigned PCW = 256;

    logic           clk = 1'b0;
    logic           rst;
    logic           cmd_start;
    logic           cmd_abort;
    logic [39:0]    cfg_duration;
    logic [PCW-1:0] cfg_port_config;
    logic           gen_ready;
    logic           snoop_valid;
    logic           snoop_ready;
    logic           snoop_last;
    logic [63:0]    snoop_keep;

    logic           busy, done, aborted, gen_start, gen_stop;
    logic [47:0]    frames_sent, bytes_sent;
    logic [PCW-1:0] gen_port_config;

    logic           sat_busy, sat_done, sat_aborted, sat_gen_start, sat_gen_stop;
    logic [7:0]     sat_frames, sat_bytes;
    logic [PCW-1:0] sat_gen_port_config;
`ifdef SPEED_TEST_STOP_TIMEOUT_EN
    logic           stop_timeout, sat_stop_timeout;
`endif

    logic [PCW-1:0] cfg_a;
    logic [PCW-1:0] cfg_b;

    int errors = 0;
    int checks = 0;
    int start_pulses = 0;
    int stop_pulses = 0;
    int done_pulses = 0;
    int overlap = 0;

    speed_test_controller #(
        .DATA_WIDTH     (512),
        .DURATION_WIDTH (40),
        .COUNT_WIDTH    (48),
        .STOP_TIMEOUT   (64)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_start       (cmd_start),
        .cmd_abort       (cmd_abort),
        .cfg_duration    (cfg_duration),
        .cfg_port_config (cfg_port_config),
        .busy            (busy),
        .done            (done),
        .aborted         (aborted),
`ifdef SPEED_TEST_STOP_TIMEOUT_EN
        .stop_timeout    (stop_timeout),
`endif
        .frames_sent     (frames_sent),
        .bytes_sent      (bytes_sent),
        .gen_ready       (gen_ready),
        .gen_start       (gen_start),
        .gen_stop        (gen_stop),
        .gen_port_config (gen_port_config),
        .snoop_valid     (snoop_valid),
        .snoop_ready     (snoop_ready),
        .snoop_last      (snoop_last),
        .snoop_keep      (snoop_keep)
    );

    // Narrow-counter copy sharing all stimulus, used to observe saturation.
    speed_test_controller #(
        .DATA_WIDTH     (512),
        .DURATION_WIDTH (40),
        .COUNT_WIDTH    (8),
        .STOP_TIMEOUT   (16)
    ) u_sat (
        .clk             (clk),
        .rst             (rst),
        .cmd_start       (cmd_start),
        .cmd_abort       (cmd_abort),
        .cfg_duration    (cfg_duration),
        .cfg_port_config (cfg_port_config),
        .busy            (sat_busy),
        .done            (sat_done),
        .aborted         (sat_aborted),
`ifdef SPEED_TEST_STOP_TIMEOUT_EN
        .stop_timeout    (sat_stop_timeout),
`endif
        .frames_sent     (sat_frames),
        .bytes_sent      (sat_bytes),
        .gen_ready       (gen_ready),
        .gen_start       (sat_gen_start),
        .gen_stop        (sat_gen_stop),
        .gen_port_config (sat_gen_port_config),
        .snoop_valid     (snoop_valid),
        .snoop_ready     (snoop_ready),
        .snoop_last      (snoop_last),
        .snoop_keep      (snoop_keep)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (gen_start) start_pulses++;
        if (gen_stop) stop_pulses++;
        if (done) done_pulses++;
        if (gen_start && gen_stop) overlap++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called with gen_start visible; drives nbeats full-keep beats and returns steps until gen_stop.
    task automatic run_until_stop(input int max, input int nbeats, input int flen, output int n);
        n = 0;
        while (n < max) begin
            snoop_valid = (n < nbeats);
            snoop_last  = ((n % flen) == flen - 1);
            snoop_keep  = '1;
            step();
            n++;
            if (gen_stop) break;
        end
        snoop_valid = 1'b0;
        snoop_last  = 1'b0;
    endtask

    task automatic accept_run(input logic [39:0] dur, input logic [PCW-1:0] cfg);
        cfg_duration    = dur;
        cfg_port_config = cfg;
        cmd_start       = 1'b1;
        step();
        cmd_start       = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got time limit expired, expected run to complete");
        $fatal(1);
    end

    initial begin
        int n;
        int s0;
        int p0;
        int d0;
        cfg_a = {8{32'hA5A5_0001}};
        cfg_b = {8{32'h5A5A_0002}};
        rst = 1'b1;
        cmd_start = 1'b0;
        cmd_abort = 1'b0;
        cfg_duration = '0;
        cfg_port_config = '0;
        gen_ready = 1'b0;
        snoop_valid = 1'b0;
        snoop_ready = 1'b1;
        snoop_last = 1'b0;
        snoop_keep = '1;
        repeat (3) step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_aborted", aborted, 0);
        check("rst_gen_start", gen_start, 0);
        check("rst_frames", frames_sent, 0);
        check("rst_cfg", gen_port_config == '0, 1);
        rst = 1'b0;
        step();

        // Basic 100-cycle run, 8-beat frames for 80 beats
        gen_ready = 1'b1;
        s0 = start_pulses; p0 = stop_pulses; d0 = done_pulses;
        accept_run(40'd100, cfg_a);
        check("basic_busy", busy, 1);
        check("basic_cfg_latched", gen_port_config == cfg_a, 1);
        check("basic_start_early", gen_start, 0);
        step();
        check("basic_start_2cyc", gen_start, 1);
        run_until_stop(200, 80, 8, n);
        check("basic_run_len", n, 100);
        step();
        check("basic_done_early", done, 0);
        step();
        check("basic_done", done, 1);
        check("basic_idle", busy, 0);
        check("basic_frames", frames_sent, 10);
        check("basic_bytes", bytes_sent, 5120);
        check("basic_aborted", aborted, 0);
        step();
        check("basic_one_start", start_pulses - s0, 1);
        check("basic_one_stop", stop_pulses - p0, 1);
        check("basic_one_done", done_pulses - d0, 1);

        // Beat while idle is not counted
        snoop_valid = 1'b1; snoop_last = 1'b1;
        step();
        snoop_valid = 1'b0; snoop_last = 1'b0;
        step(); step();
        check("idle_beat_frames", frames_sent, 10);
        check("idle_beat_bytes", bytes_sent, 5120);

        // Abort 10 cycles into a 1000-cycle run
        p0 = stop_pulses;
        accept_run(40'd1000, cfg_b);
        step();
        check("abort_started", gen_start, 1);
        repeat (10) step();
        cmd_abort = 1'b1;
        step();
        cmd_abort = 1'b0;
        check("abort_stop_next", gen_stop, 1);
        check("abort_flag", aborted, 1);
        step();
        check("abort_stop_single", gen_stop, 0);
        step();
        check("abort_done", done, 1);
        repeat (3) step();
        check("abort_one_stop", stop_pulses - p0, 1);
        check("abort_sticky", aborted, 1);

        // Zero duration: straight to done, never started
        s0 = start_pulses;
        accept_run(40'd0, cfg_a);
        check("zero_aborted_clr", aborted, 0);
        check("zero_frames", frames_sent, 0);
        check("zero_bytes", bytes_sent, 0);
        step();
        check("zero_done", done, 1);
        step(); step();
        check("zero_no_start", start_pulses - s0, 0);

        // Ready low 50 cycles in ARM, then low 20 cycles in STOPPING
        gen_ready = 1'b0;
        s0 = start_pulses; d0 = done_pulses;
        accept_run(40'd30, cfg_b);
        repeat (50) step();
        check("delay_no_start", start_pulses - s0, 0);
        check("delay_arm_busy", busy, 1);
        gen_ready = 1'b1;
        step();
        check("delay_start", gen_start, 1);
        snoop_valid = 1'b1; snoop_last = 1'b0; snoop_keep = 64'h0F0F;
        step();
        snoop_keep = 64'h1;
        step();
        snoop_keep = 64'hFFFF_FFFF; snoop_last = 1'b1;
        step();
        snoop_valid = 1'b0; snoop_last = 1'b0; snoop_keep = '1;
        run_until_stop(100, 0, 1, n);
        check("delay_run_len", n + 3, 30);
        gen_ready = 1'b0;
        repeat (5) step();
        snoop_valid = 1'b1; snoop_last = 1'b1;
        step();
        snoop_valid = 1'b0; snoop_last = 1'b0;
        repeat (14) step();
        check("delay_no_done", done_pulses - d0, 0);
        check("delay_stopping_busy", busy, 1);
        gen_ready = 1'b1;
        step();
        check("delay_done_early", done, 0);
        step();
        check("delay_done", done, 1);
        check("delay_frames", frames_sent, 2);
        check("delay_bytes", bytes_sent, 105);

        // Abort on the expiry cycle of a 5-cycle run
        p0 = stop_pulses;
        accept_run(40'd5, cfg_a);
        step();
        check("expab_start", gen_start, 1);
        repeat (4) step();
        cmd_abort = 1'b1;
        step();
        cmd_abort = 1'b0;
        check("expab_stop", gen_stop, 1);
        step();
        check("expab_stop_single", gen_stop, 0);
        check("expab_aborted", aborted, 1);
        step();
        check("expab_done", done, 1);
        step();
        check("expab_one_stop", stop_pulses - p0, 1);

        // cmd_start during RUN is ignored
        s0 = start_pulses;
        accept_run(40'd50, cfg_a);
        check("busy_aborted_clr", aborted, 0);
        step();
        check("busy_start", gen_start, 1);
        repeat (10) step();
        accept_run(40'd3, cfg_b);
        check("busy_cfg_held", gen_port_config == cfg_a, 1);
        run_until_stop(100, 0, 1, n);
        check("busy_run_len", n, 39);
        step(); step();
        check("busy_done", done, 1);
        check("busy_one_start", start_pulses - s0, 1);

        // Reset in the middle of RUN
        accept_run(40'd100, cfg_b);
        step();
        run_until_stop(20, 20, 1, n);
        check("rstrun_frames", frames_sent, 20);
        check("rstrun_bytes_trail", bytes_sent, 19 * 64);
        p0 = stop_pulses;
        rst = 1'b1;
        step();
        check("rstrun_busy", busy, 0);
        check("rstrun_frames_clr", frames_sent, 0);
        check("rstrun_bytes_clr", bytes_sent, 0);
        check("rstrun_cfg_clr", gen_port_config == '0, 1);
        check("rstrun_stop", gen_stop, 0);
        rst = 1'b0;
        repeat (3) step();
        check("rstrun_no_stop", stop_pulses - p0, 0);
        check("rstrun_idle", busy, 0);

        // 300 single-beat frames: wide counters exact, narrow copy saturates
        accept_run(40'd400, cfg_a);
        step();
        check("sat_start", gen_start, 1);
        run_until_stop(500, 300, 1, n);
        check("sat_run_len", n, 400);
        step(); step();
        check("sat_done", done, 1);
        check("sat_wide_frames", frames_sent, 300);
        check("sat_wide_bytes", bytes_sent, 19200);
        check("sat_narrow_frames", sat_frames, 255);
        check("sat_narrow_bytes", sat_bytes, 255);

`ifdef SPEED_TEST_STOP_TIMEOUT_EN
        // Narrow copy has a 16-cycle STOPPING watchdog; wide copy keeps waiting
        accept_run(40'd5, cfg_b);
        step();
        run_until_stop(20, 0, 1, n);
        gen_ready = 1'b0;
        repeat (16) step();
        check("to_flag", sat_stop_timeout, 1);
        check("to_done_early", sat_done, 0);
        step();
        check("to_done", sat_done, 1);
        check("to_aborted", sat_aborted, 1);
        check("to_wide_waiting", busy, 1);
        check("to_wide_no_flag", stop_timeout, 0);
        gen_ready = 1'b1;
        step(); step();
        check("to_wide_done", done, 1);
`endif

        check("start_stop_overlap", overlap, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/speed_test_controller.md
Name: speed_test_controller

Overview:
- Sequences one timed transmit run of the frame generator: latches a port configuration, waits for generator ready, pulses start, and counts the run duration in clock cycles.
- At expiry or on abort, pulses stop, waits for the generator to return to ready, then reports completion.
- Snoops the generator's AXIS output handshake and counts frames and bytes sent during the run.
- Sits between the host register block and the frame generator.

Parameters:
- DATA_WIDTH, 512, generator AXIS data width in bits; keep width is DATA_WIDTH/8.
- DURATION_WIDTH, 40, width of the duration and cycle counter.
- COUNT_WIDTH, 48, width of the frame and byte statistics counters.
- STOP_TIMEOUT, 65536, cycles allowed in STOPPING before abandoning the wait (optional feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_start  in  1  one-cycle request to begin a run
- cmd_abort  in  1  one-cycle request to end the run early
- cfg_duration  in  DURATION_WIDTH  run length in cycles; sampled with cmd_start
- cfg_port_config  in  256  generator config; sampled with cmd_start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the run completes
- aborted  out  1  sticky; run ended by abort or timeout; cleared on next accepted cmd_start
- frames_sent  out  COUNT_WIDTH  AXIS frames with last seen during the current or last run
- bytes_sent  out  COUNT_WIDTH  popcount of keep over accepted beats
- gen_ready  in  1  generator ready
- gen_start  out  1  one-cycle start pulse to the generator
- gen_stop  out  1  one-cycle stop pulse to the generator
- gen_port_config  out  256  latched config, held stable from accept to next accept
- snoop_valid  in  1  generator axis_m_valid
- snoop_ready  in  1  generator axis_m_ready
- snoop_last  in  1  generator axis_m_last
- snoop_keep  in  DATA_WIDTH/8  generator axis_m_keep

Behaviour:
- Reset values: all outputs 0, gen_port_config 0, state IDLE, all counters 0. Reset mid-run returns to IDLE with no stop pulse; the generator shares the same reset.
- IDLE:
  - cmd_start accepted only here; it latches config and duration, clears counters and aborted, and moves to ARM next cycle.
  - cmd_start while busy is ignored.
  - If cfg_duration==0: go straight to DONE; the generator is never started.
- ARM: wait for gen_ready==1, then assert gen_start for exactly one cycle, load cycle counter = duration, and enter RUN.
  - cmd_abort in ARM: set aborted and go to DONE without starting.
- RUN: counter decrements every cycle.
  - When counter==1, or on cmd_abort (sets aborted), assert gen_stop for one cycle and enter STOPPING.
  - Run length from gen_start cycle to gen_stop cycle is exactly duration cycles.
  - Abort on the same cycle as expiry: a single stop pulse; aborted is set.
- STOPPING: wait for gen_ready==1, then go to DONE. Counting continues here, so in-flight frames are included.
- DONE: done=1 for one cycle, then IDLE. Counters hold their values until the next accepted start.
- Statistics:
  - A beat counts when snoop_valid && snoop_ready in ARM/RUN/STOPPING.
  - frames_sent += 1 on counted beats with last.
  - bytes_sent += popcount(keep), computed by a combinational adder tree and registered once; totals trail the beat by 1 cycle.
  - Counters saturate at all-ones; no wrap.
- gen_start and gen_stop are never high in the same cycle. At most one gen_start per run.

Optional Feature:
- Macro SPEED_TEST_STOP_TIMEOUT_EN.
- Defined: a watchdog counts cycles in STOPPING. At STOP_TIMEOUT it forces DONE, sets aborted, and raises the sticky output stop_timeout (extra 1-bit port, cleared on accepted start).
- Undefined: STOPPING waits indefinitely; no stop_timeout port and no watchdog logic.

Decomposition:
- Package speed_test_pkg holds:
  - state enum (IDLE, ARM, RUN, STOPPING, DONE)
  - PORT_CONFIG_WIDTH=256
  - shared counter width constants
- Sub-module keep_popcount (DATA_WIDTH/8 input, registered count output) isolates the byte-count tree.

Test Plan:
- Basic run:
  - Stimulus: duration=100, gen_ready=1, sink always ready, generator emits 8-beat frames with full keep.
  - Response: gen_start 2 cycles after cmd_start; gen_stop exactly 100 cycles after gen_start; done once; frames_sent/bytes_sent match the model (e.g., 64 bytes × beats).
- Duration zero:
  - Stimulus: cmd_start with duration 0.
  - Response: gen_start never asserted; done 2 cycles later; counters 0; aborted 0.
- Delayed ready:
  - Stimulus: gen_ready low for 50 cycles after cmd_start.
  - Response: stays in ARM; gen_start the cycle gen_ready rises.
  - Stimulus: gen_ready low 20 cycles after gen_stop.
  - Response: done only after gen_ready returns.
- Abort:
  - Stimulus: cmd_abort 10 cycles into a 1000-cycle run.
  - Response: a single gen_stop next cycle; aborted=1.
  - Stimulus: abort on the expiry cycle.
  - Response: a single stop pulse.
- Busy start and reset:
  - Stimulus: cmd_start during RUN.
  - Response: ignored; config unchanged.
  - Stimulus: rst mid-RUN.
  - Response: all outputs 0 the next cycle.
- Saturation and timeout:
  - Stimulus: force counters near max via a short COUNT_WIDTH=8 build.
  - Response: frames_sent holds at 255.
  - Stimulus: with SPEED_TEST_STOP_TIMEOUT_EN, STOP_TIMEOUT=16, gen_ready held low.
  - Response: done and stop_timeout after 16 cycles in STOPPING.
